// File: rtl/memory_stage.sv
// memory_stage: Y86-64 pipeline MEM stage with a byte-addressed, little-endian
// data memory and an optional multi-cycle access latency (ACCESS_LAT).
// Build macro MEM_ALIGN_CHECK_EN: when defined, an 8-byte access whose address
// is not a multiple of 8 is reported as an address error (ADR).
module memory_stage #(
    parameter int MEM_BYTES  = 1024,
    parameter int ACCESS_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  M_status,
    input  logic [3:0]  M_icode,
    input  logic        M_cond,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_destE,
    input  logic [3:0]  M_destM,
    output logic [1:0]  m_status,
    output logic [3:0]  m_icode,
    output logic [63:0] m_valE,
    output logic [63:0] m_valM,
    output logic [3:0]  m_destE,
    output logic [3:0]  m_destM,
    output logic        m_stall
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CW = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_ADR = 2'd2;

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [63:0]     rdata_q, rdata_d;
    logic [7:0]      mem_q [MEM_BYTES];

    logic            is_read;
    logic            is_write;
    logic            need_access;
    logic            addr_err;
    logic            access_ok;
    logic            mem_we;
    logic            stall;
    logic [63:0]     addr;
    logic [AW-1:0]   base;
    logic [63:0]     rdata_comb;

    // M_cond is carried by the pipeline register but has no role in this stage.
    logic unused_cond;
    assign unused_cond = M_cond;

    assign m_icode = M_icode;
    assign m_valE  = M_valE;
    assign m_destE = M_destE;
    assign m_destM = M_destM;

    // Decode access kind, pick the address source and flag out-of-range addresses.
    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        addr     = M_valE;
        case (M_icode)
            I_RMMOVQ, I_CALL, I_PUSHQ: is_write = 1'b1;
            I_MRMOVQ:                  is_read  = 1'b1;
            I_RET, I_POPQ: begin
                is_read = 1'b1;
                addr    = M_valA;
            end
            default: ;
        endcase
        need_access = (is_read | is_write) & (M_status == STAT_AOK);
        addr_err    = addr[63] | (addr > 64'(MEM_BYTES - 8));
`ifdef MEM_ALIGN_CHECK_EN
        addr_err    = addr_err | (addr[2:0] != 3'b000);
`else
        addr_err    = addr_err | 1'b0;
`endif
        addr_err    = addr_err & need_access;
        access_ok   = need_access & ~addr_err;
        base        = addr[AW-1:0];
        m_status    = addr_err ? STAT_ADR : M_status;
    end

    // Assemble the 8-byte little-endian word starting at the selected address.
    always_comb begin
        rdata_comb = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            rdata_comb[i*8 +: 8] = mem_q[base + AW'(i)];
        end
    end

    // Next-state, stall, write-enable and load-data selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        mem_we  = 1'b0;
        m_valM  = '0;
        if (ACCESS_LAT == 0) begin
            mem_we = access_ok & is_write;
            if (access_ok && is_read) begin
                m_valM = rdata_comb;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access_ok) begin
                        stall   = 1'b1;
                        state_d = S_WAIT;
                        cnt_d   = CW'(ACCESS_LAT - 1);
                    end
                end
                S_WAIT: begin
                    stall = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                        if (is_read) begin
                            rdata_d = rdata_comb;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    mem_we  = access_ok & is_write;
                    if (access_ok && is_read) begin
                        m_valM = rdata_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Reset overrides the stage: no stall and no memory update while held.
        mem_we = mem_we & ~rst;
    end

    assign m_stall = stall & ~rst;

    // Access-latency FSM, wait counter and registered load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Data memory store; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                mem_q[base + AW'(i)] <= M_valA[i*8 +: 8];
            end
        end
    end

endmodule
